btn_event: RTL and testbench

Button gesture classifier that sits directly downstream of the debouncer. It takes one debounced button level and turns it into single-cycle event pulses: press, release, click, double-click, long-press, and optional auto-repeat. UI and control logic consume these pulses instead of raw levels, so no consumer needs its own timing counters.

---
 rtl/btn_event_pkg.sv | 23 ++
 rtl/btn_edge.sv | 31 +++
 rtl/btn_event.sv | 149 ++++++++++++++
 tb/tb_btn_event.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared state encoding and 50 MHz default timing for the button gesture classifier.
// Revision 1.0
`default_nettype none

package btn_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_t;

  // 1 s, 250 ms and 100 ms at 50 MHz; a 26-bit counter covers the largest.
  localparam int unsigned DEF_LONG_PERIOD   = 50_000_000;
  localparam int unsigned DEF_DCLICK_WINDOW = 12_500_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 5_000_000;
  localparam int unsigned DEF_CNT_W         = 26;

endpackage

`default_nettype wire

// File: rtl/btn_edge.sv
// btn_edge: two-stage staging of a debounced level with registered rise/fall detection.
// Revision 1.0
`default_nettype none

module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic lvl_q;
  logic lvl_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= 1'b0;
      lvl_p <= 1'b0;
    end else begin
      lvl_q <= level;
      lvl_p <= lvl_q;
    end
  end

  assign rise = lvl_q & ~lvl_p;
  assign fall = ~lvl_q & lvl_p;

endmodule

`default_nettype wire

// File: rtl/btn_event.sv
// btn_event: turns one debounced button level into press/release/click/double/long/repeat pulses.
// Revision 1.0 -- auto-repeat is compiled in with BTN_EVENT_REPEAT_EN.
`default_nettype none

module btn_event
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_PERIOD   = DEF_LONG_PERIOD,
  parameter int unsigned DCLICK_WINDOW = DEF_DCLICK_WINDOW,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press,
  // "release" is a reserved word, hence the suffix
  output logic release_evt,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_PERIOD - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_WINDOW - 1);

  logic rise;
  logic fall;

  btn_edge u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_level),
    .rise  (rise),
    .fall  (fall)
  );

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             press_n;
  logic             release_n;
  logic             click_n;
  logic             dclick_n;
  logic             long_n;
  logic             rpt_n;

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    press_n   = 1'b0;
    release_n = 1'b0;
    click_n   = 1'b0;
    dclick_n  = 1'b0;
    long_n    = 1'b0;
    rpt_n     = 1'b0;
    // Edges are tested before counter terminals so they win any tie.
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_PRESS1;
          press_n = 1'b1;
        end
      end
      ST_PRESS1: begin
        if (fall) begin
          state_n   = ST_GAP;
          release_n = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = ST_HELD;
          long_n  = 1'b1;
        end
      end
      ST_GAP: begin
        if (rise) begin
          state_n  = ST_PRESS2;
          press_n  = 1'b1;
          dclick_n = 1'b1;
        end else if (cnt == DCLICK_LAST) begin
          state_n = ST_IDLE;
          click_n = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          state_n   = ST_IDLE;
          release_n = 1'b1;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_n   = ST_IDLE;
          release_n = 1'b1;
        end
`ifdef BTN_EVENT_REPEAT_EN
        else if (cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
          rpt_n   = 1'b1;
          cnt_clr = 1'b1;
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n != state) cnt_clr = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (cnt_clr)        cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press        <= 1'b0;
      release_evt  <= 1'b0;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      press        <= press_n;
      release_evt  <= release_n;
      click        <= click_n;
      double_click <= dclick_n;
      long_press   <= long_n;
    end
  end

`ifdef BTN_EVENT_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) repeat_tick <= 1'b0;
    else        repeat_tick <= rpt_n;
  end
`else
  assign repeat_tick = 1'b0;
  logic unused_rpt;
  assign unused_rpt = rpt_n ^ (REPEAT_PERIOD == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_event.sv
// tb_btn_event: scoreboard bench for btn_event with LONG_PERIOD=20, DCLICK_WINDOW=8, REPEAT_PERIOD=5.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_btn_event;

  localparam int LP = 20;
  localparam int DW = 8;
  localparam int RP = 5;

  localparam logic [5:0] EV_PRESS = 6'b000001;
  localparam logic [5:0] EV_REL   = 6'b000010;
  localparam logic [5:0] EV_CLICK = 6'b000100;
  localparam logic [5:0] EV_DBL   = 6'b001000;
  localparam logic [5:0] EV_LONG  = 6'b010000;
  localparam logic [5:0] EV_RPT   = 6'b100000;

  typedef struct packed {
    logic [31:0] at;
    logic [5:0]  ev;
  } evt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_level = 1'b0;
  logic press, release_evt, click, double_click, long_press, repeat_tick;

  btn_event #(
    .LONG_PERIOD   (LP),
    .DCLICK_WINDOW (DW),
    .REPEAT_PERIOD (RP),
    .CNT_W         (26)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_level    (btn_level),
    .press        (press),
    .release_evt  (release_evt),
    .click        (click),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_tick  (repeat_tick)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  evt_t exp_q[$];
  evt_t obs_q[$];
  evt_t mon_e;

  wire [5:0] outs = {repeat_tick, long_press, double_click, click, release_evt, press};

  always @(posedge clk) cyc <= cyc + 1;

  // Records every cycle in which any output pulse is high.
  always @(posedge clk) begin
    #1;
    if (outs != 6'b0) begin
      mon_e.at = 32'(cyc);
      mon_e.ev = outs;
      obs_q.push_back(mon_e);
    end
  end

  task automatic expect_ev(input int at, input logic [5:0] ev);
    evt_t e;
    e.at = 32'(at);
    e.ev = ev;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic lvl, input int n);
    btn_level = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    evt_t o;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (outs !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b, expected 000000", outs);
      end
    end
    rst_n = 1'b1;
    hold(1'b0, 10);
    n_checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0];
      n_fail++;
      $display("FAIL reset_idle: got %0d events (first ev=%b at %0d), expected 0", obs_q.size(), o.ev, o.at);
      obs_q.delete();
    end
  endtask

  task automatic test_short_click;
    evt_t e, o;
    int t0;
    t0 = cyc;
    expect_ev(t0 + 2, EV_PRESS);
    expect_ev(t0 + 7, EV_REL);
    expect_ev(t0 + 7 + DW, EV_CLICK);
    hold(1'b1, 5);
    hold(1'b0, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL short_click: got no event, expected ev=%b at %0d", e.ev, e.at);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL short_click: got ev=%b at %0d, expected ev=%b at %0d", o.ev, o.at, e.ev, e.at);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0];
      n_fail++;
      $display("FAIL short_click_extra: got ev=%b at %0d, expected no further events", o.ev, o.at);
      obs_q.delete();
    end
  endtask

  task automatic test_double_click;
    evt_t e, o;
    int t0;
    t0 = cyc;
    expect_ev(t0 + 2, EV_PRESS);
    expect_ev(t0 + 5, EV_REL);
    expect_ev(t0 + 9, EV_PRESS | EV_DBL);
    expect_ev(t0 + 12, EV_REL);
    hold(1'b1, 3);
    hold(1'b0, 4);
    hold(1'b1, 3);
    hold(1'b0, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL double_click: got no event, expected ev=%b at %0d", e.ev, e.at);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL double_click: got ev=%b at %0d, expected ev=%b at %0d", o.ev, o.at, e.ev, e.at);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0];
      n_fail++;
      $display("FAIL double_click_extra: got ev=%b at %0d, expected no further events", o.ev, o.at);
      obs_q.delete();
    end
  endtask

  task automatic test_long_repeat(input int hold_n);
    evt_t e, o;
    int t0, t_rel;
    t0 = cyc;
    t_rel = t0 + hold_n + 2;
    expect_ev(t0 + 2, EV_PRESS);
    expect_ev(t0 + 2 + LP, EV_LONG);
`ifdef BTN_EVENT_REPEAT_EN
    for (int k = t0 + 2 + LP + RP; k < t_rel; k += RP) expect_ev(k, EV_RPT);
`endif
    expect_ev(t_rel, EV_REL);
    hold(1'b1, hold_n);
    hold(1'b0, 15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL long_repeat(%0d): got no event, expected ev=%b at %0d", hold_n, e.ev, e.at);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL long_repeat(%0d): got ev=%b at %0d, expected ev=%b at %0d", hold_n, o.ev, o.at, e.ev, e.at);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0];
      n_fail++;
      $display("FAIL long_repeat_extra(%0d): got ev=%b at %0d, expected no further events", hold_n, o.ev, o.at);
      obs_q.delete();
    end
  endtask

  task automatic test_release_at_terminal;
    evt_t e, o;
    int t0;
    t0 = cyc;
    expect_ev(t0 + 2, EV_PRESS);
    expect_ev(t0 + 22, EV_REL);
    expect_ev(t0 + 22 + DW, EV_CLICK);
    hold(1'b1, LP);
    hold(1'b0, 15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL release_at_terminal: got no event, expected ev=%b at %0d", e.ev, e.at);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL release_at_terminal: got ev=%b at %0d, expected ev=%b at %0d", o.ev, o.at, e.ev, e.at);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0];
      n_fail++;
      $display("FAIL release_at_terminal_extra: got ev=%b at %0d, expected no further events", o.ev, o.at);
      obs_q.delete();
    end
  endtask

  task automatic test_window_expiry;
    evt_t e, o;
    int t0;
    t0 = cyc;
    expect_ev(t0 + 2, EV_PRESS);
    expect_ev(t0 + 5, EV_REL);
    expect_ev(t0 + 13, EV_PRESS | EV_DBL);
    expect_ev(t0 + 16, EV_REL);
    hold(1'b1, 3);
    hold(1'b0, DW);
    hold(1'b1, 3);
    hold(1'b0, 15);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL window_expiry: got no event, expected ev=%b at %0d", e.ev, e.at);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL window_expiry: got ev=%b at %0d, expected ev=%b at %0d", o.ev, o.at, e.ev, e.at);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0];
      n_fail++;
      $display("FAIL window_expiry_extra: got ev=%b at %0d, expected no further events", o.ev, o.at);
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    evt_t e, o;
    int t0, r;
    t0 = cyc;
    expect_ev(t0 + 2, EV_PRESS);
    expect_ev(t0 + 2 + LP, EV_LONG);
    btn_level = 1'b1;
    repeat (2 + LP) @(posedge clk);
    #2;
    n_checks++;
    if (long_press !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_long: got long_press=%b, expected 1", long_press);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b, expected 000000", outs);
    end
    repeat (3) @(negedge clk);
    r = cyc;
    expect_ev(r + 2, EV_PRESS);
    expect_ev(r + 2 + LP, EV_LONG);
    expect_ev(r + 27, EV_REL);
    rst_n = 1'b1;
    hold(1'b1, 25);
    hold(1'b0, 10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL reset_mid: got no event, expected ev=%b at %0d", e.ev, e.at);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL reset_mid: got ev=%b at %0d, expected ev=%b at %0d", o.ev, o.at, e.ev, e.at);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0];
      n_fail++;
      $display("FAIL reset_mid_extra: got ev=%b at %0d, expected no further events", o.ev, o.at);
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_short_click();
    test_double_click();
    test_long_repeat(41);
    test_long_repeat(40);
    test_release_at_terminal();
    test_window_expiry();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
